// File: rtl/traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// traffic_lamp_monitor
//
// Purpose:
//   Sits between a traffic controller and the lamp drivers of a four-head
//   junction (main M1, main M2, main turn MT, side S). While in RUN it passes
//   the controller's lamp codes through with one register stage. It watches
//   for unsafe behaviour and latches the first confirmed fault:
//     1 illegal code   - any head not exactly one of red/yellow/green
//     2 conflict       - S open together with any main head, or MT open
//                        together with M2
//     3 skipped yellow - any head jumping from green straight to red
//   Level faults (1, 2) must persist FILTER consecutive cycles. A confirmed
//   fault forces all-red flashing until the operator clears it while the
//   controller outputs are clean, followed by an all-red recovery period.
//
// State table:
//   state   | meaning
//   INIT    | after reset: all red for STARTUP_CYC cycles
//   RUN     | pass-through, fault detection active
//   FLASH   | latched fault: all lamps flash red / off
//   RECOVER | fault cleared: all red for STARTUP_CYC cycles
//
// Ports:
//   clk                  sole clock, rising edge
//   rst                  synchronous active-high reset
//   light_M1/M2/MT/S [2:0] controller lamp codes (100 red, 010 yel, 001 grn)
//   clr_fault            operator fault clear, level-sampled in FLASH only
//   lamp_M1/M2/MT/S  [2:0] registered lamp drive, same encoding
//   fault                latched fault indicator
//   fault_code       [1:0] first confirmed fault (0 none, 1 illegal,
//                        2 conflict, 3 skipped yellow)
//   mode             [1:0] current state (0 INIT, 1 RUN, 2 FLASH, 3 RECOVER)
// -----------------------------------------------------------------------------
module traffic_lamp_monitor #(
  parameter int STARTUP_CYC = 8,
  parameter int BLINK_HALF  = 4,
  parameter int FILTER      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] mode
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_CONFL   = 2'd2;
  localparam logic [1:0] CODE_SKIP    = 2'd3;

  localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  // A level fault confirms once FILTER-1 true cycles are already counted
  // and the current sample is also true.
  localparam logic [3:0]    FILT_LAST  = 4'(FILTER - 1);

  localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};
  localparam logic [11:0] ALL_OFF = {OFF, OFF, OFF, OFF};

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_FLASH   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t          state_q,     state_d;
  logic [SW-1:0]   start_cnt_q, start_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q,  blink_on_d;
  logic [3:0]      ill_cnt_q,   ill_cnt_d;
  logic [3:0]      con_cnt_q,   con_cnt_d;
  logic            fault_q,     fault_d;
  logic [1:0]      code_q,      code_d;
  logic            first_run_q, first_run_d;
  logic [11:0]     lamps_q,     lamps_d;
  logic [3:0][2:0] prev_q;

  logic [3:0][2:0] light_now;
  logic            illegal_now;
  logic            conflict_now;
  logic            skip_now;
  logic            ill_hit;
  logic            con_hit;
  logic            skip_hit;

  // Index 3 = M1, 2 = M2, 1 = MT, 0 = S.
  assign light_now = {light_M1, light_M2, light_MT, light_S};

  function automatic logic is_legal(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input condition decode
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal_now = 1'b0;
    skip_now    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!is_legal(light_now[i])) begin
        illegal_now = 1'b1;
      end
      if ((prev_q[i] == GRN) && (light_now[i] == RED)) begin
        skip_now = 1'b1;
      end
    end
  end

  // Any non-red code counts as "open", including illegal ones. M1 may run
  // alongside M2 and MT; those pairs are deliberately not checked.
  assign conflict_now =
      ((light_S != RED) &&
       ((light_M1 != RED) || (light_M2 != RED) || (light_MT != RED))) ||
      ((light_MT != RED) && (light_M2 != RED));

  assign ill_hit  = illegal_now  && (ill_cnt_q >= FILT_LAST);
  assign con_hit  = conflict_now && (con_cnt_q >= FILT_LAST);
  // The previous-value registers hold INIT/RECOVER history on the first RUN
  // cycle, so a green->red seen there is not a real controller transition.
  assign skip_hit = skip_now && !first_run_q;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    ill_cnt_d   = 4'd0;
    con_cnt_d   = 4'd0;
    fault_d     = fault_q;
    code_d      = code_q;
    first_run_d = 1'b0;
    lamps_d     = ALL_RED;

    case (state_q)
      S_INIT, S_RECOVER: begin
        if (start_cnt_q == START_LAST) begin
          state_d     = S_RUN;
          start_cnt_d = '0;
          first_run_d = 1'b1;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end

      S_RUN: begin
        ill_cnt_d = illegal_now  ? sat_inc(ill_cnt_q) : 4'd0;
        con_cnt_d = conflict_now ? sat_inc(con_cnt_q) : 4'd0;
        if (ill_hit || con_hit || skip_hit) begin
          state_d     = S_FLASH;
          fault_d     = 1'b1;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          ill_cnt_d   = 4'd0;
          con_cnt_d   = 4'd0;
          if (ill_hit) begin
            code_d = CODE_ILLEGAL;
          end else if (con_hit) begin
            code_d = CODE_CONFL;
          end else begin
            code_d = CODE_SKIP;
          end
        end
      end

      S_FLASH: begin
        if (clr_fault && !illegal_now && !conflict_now) begin
          state_d     = S_RECOVER;
          fault_d     = 1'b0;
          code_d      = CODE_NONE;
          start_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = !blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // Lamps are registered from the state being entered so that the first
    // cycle of every state already shows that state's drive.
    case (state_d)
      S_RUN:   lamps_d = light_now;
      S_FLASH: lamps_d = blink_on_d ? ALL_RED : ALL_OFF;
      default: lamps_d = ALL_RED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      start_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      ill_cnt_q   <= 4'd0;
      con_cnt_q   <= 4'd0;
      fault_q     <= 1'b0;
      code_q      <= CODE_NONE;
      first_run_q <= 1'b0;
      lamps_q     <= ALL_RED;
      prev_q      <= {RED, RED, RED, RED};
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      ill_cnt_q   <= ill_cnt_d;
      con_cnt_q   <= con_cnt_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      first_run_q <= first_run_d;
      lamps_q     <= lamps_d;
      prev_q      <= light_now;
    end
  end

  assign lamp_M1    = lamps_q[11:9];
  assign lamp_M2    = lamps_q[8:6];
  assign lamp_MT    = lamps_q[5:3];
  assign lamp_S     = lamps_q[2:0];
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_lamp_monitor
//
// Directed bench for traffic_lamp_monitor with default parameters
// (STARTUP_CYC=8, BLINK_HALF=4, FILTER=2). Inputs change 1 ns after a rising
// edge; outputs are checked at that point, i.e. they show the result of the
// edge just taken.
// -----------------------------------------------------------------------------
module tb_traffic_lamp_monitor;

  localparam logic [11:0] ALL_RED = {3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [11:0] ALL_OFF = 12'h000;
  localparam logic [11:0] BASE    = {3'b001, 3'b001, 3'b100, 3'b100};

  logic       clk;
  logic       rst;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       clr_fault;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] mode;
  logic [11:0] lamps;

  int checks = 0;
  int errors = 0;

  assign lamps = {lamp_M1, lamp_M2, lamp_MT, lamp_S};

  traffic_lamp_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light_M1  (light_M1),
    .light_M2  (light_M2),
    .light_MT  (light_MT),
    .light_S   (light_S),
    .clr_fault (clr_fault),
    .lamp_M1   (lamp_M1),
    .lamp_M2   (lamp_M2),
    .lamp_MT   (lamp_MT),
    .lamp_S    (lamp_S),
    .fault     (fault),
    .fault_code(fault_code),
    .mode      (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [2:0] m1, input logic [2:0] m2,
                            input logic [2:0] mt, input logic [2:0] s);
    light_M1 = m1;
    light_M2 = m2;
    light_MT = mt;
    light_S  = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_fault = 1'b0;
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (lamps !== ALL_RED || mode !== 2'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: lamps=%h mode=%0d fault=%b code=%0d, want lamps=%h mode=0 fault=0 code=0",
               lamps, mode, fault, fault_code, ALL_RED);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mode !== 2'd0 || lamps !== ALL_RED) begin
        errors++;
        $display("FAIL init_cycle%0d: mode=%0d lamps=%h, want mode=0 lamps=%h", i, mode, lamps, ALL_RED);
      end
      tick();
    end
    checks++;
    if (mode !== 2'd1 || lamps !== BASE) begin
      errors++;
      $display("FAIL init_to_run: mode=%0d lamps=%h, want mode=1 lamps=%h", mode, lamps, BASE);
    end
  endtask

  task automatic test_first_run_suppress();
    // First RUN cycle: M2 goes 001 -> 100 but must not be flagged.
    set_lights(3'b001, 3'b100, 3'b100, 3'b100);
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0 || lamps !== {3'b001, 3'b100, 3'b100, 3'b100}) begin
      errors++;
      $display("FAIL first_run_suppress: mode=%0d fault=%b lamps=%h, want mode=1 fault=0 lamps=%h",
               mode, fault, lamps, {3'b001, 3'b100, 3'b100, 3'b100});
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    tick();
    checks++;
    if (mode !== 2'd1 || lamps !== BASE) begin
      errors++;
      $display("FAIL run_track: mode=%0d lamps=%h, want mode=1 lamps=%h", mode, lamps, BASE);
    end
  endtask

  task automatic test_glitch();
    set_lights(3'b001, 3'b001, 3'b100, 3'b010);
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0 || lamps !== {3'b001, 3'b001, 3'b100, 3'b010}) begin
      errors++;
      $display("FAIL glitch_1cyc: mode=%0d fault=%b lamps=%h, want mode=1 fault=0 lamps=%h",
               mode, fault, lamps, {3'b001, 3'b001, 3'b100, 3'b010});
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0 || lamps !== BASE) begin
      errors++;
      $display("FAIL glitch_cleared: mode=%0d fault=%b lamps=%h, want mode=1 fault=0 lamps=%h",
               mode, fault, lamps, BASE);
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b010);
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL conflict_cyc1: mode=%0d fault=%b, want mode=1 fault=0", mode, fault);
    end
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1 || fault_code !== 2'd2 || lamps !== ALL_RED) begin
      errors++;
      $display("FAIL conflict_confirm: mode=%0d fault=%b code=%0d lamps=%h, want mode=2 fault=1 code=2 lamps=%h",
               mode, fault, fault_code, lamps, ALL_RED);
    end
  endtask

  task automatic test_clear();
    clr_fault = 1'b1;
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL clear_blocked: mode=%0d fault=%b code=%0d, want mode=2 fault=1 code=2",
               mode, fault, fault_code);
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    checks++;
    if (mode !== 2'd3 || fault !== 1'b0 || fault_code !== 2'd0 || lamps !== ALL_RED) begin
      errors++;
      $display("FAIL clear_accept: mode=%0d fault=%b code=%0d lamps=%h, want mode=3 fault=0 code=0 lamps=%h",
               mode, fault, fault_code, lamps, ALL_RED);
    end
    // clr_fault left high through RECOVER: it must be ignored there.
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mode !== 2'd3 || lamps !== ALL_RED) begin
        errors++;
        $display("FAIL recover_cycle%0d: mode=%0d lamps=%h, want mode=3 lamps=%h", i, mode, lamps, ALL_RED);
      end
      tick();
    end
    checks++;
    if (mode !== 2'd1 || lamps !== BASE) begin
      errors++;
      $display("FAIL recover_to_run: mode=%0d lamps=%h, want mode=1 lamps=%h", mode, lamps, BASE);
    end
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_run: mode=%0d fault=%b, want mode=1 fault=0", mode, fault);
    end
    clr_fault = 1'b0;
  endtask

  task automatic test_skip_yellow();
    logic [11:0] exp;
    tick();
    set_lights(3'b001, 3'b100, 3'b100, 3'b100);
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1 || fault_code !== 2'd3) begin
      errors++;
      $display("FAIL skip_confirm: mode=%0d fault=%b code=%0d, want mode=2 fault=1 code=3",
               mode, fault, fault_code);
    end
    for (int i = 0; i < 16; i++) begin
      exp = ((i % 8) < 4) ? ALL_RED : ALL_OFF;
      checks++;
      if (lamps !== exp || mode !== 2'd2) begin
        errors++;
        $display("FAIL flash_cycle%0d: lamps=%h mode=%0d, want lamps=%h mode=2", i, lamps, mode, exp);
      end
      tick();
    end
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    checks++;
    if (mode !== 2'd3 || fault !== 1'b0) begin
      errors++;
      $display("FAIL skip_clear: mode=%0d fault=%b, want mode=3 fault=0", mode, fault);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (mode !== 2'd1 || lamps !== {3'b001, 3'b100, 3'b100, 3'b100}) begin
      errors++;
      $display("FAIL skip_back_to_run: mode=%0d lamps=%h, want mode=1 lamps=%h",
               mode, lamps, {3'b001, 3'b100, 3'b100, 3'b100});
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    tick();
  endtask

  task automatic test_priority();
    set_lights(3'b001, 3'b001, 3'b111, 3'b100);
    tick();
    checks++;
    if (mode !== 2'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL prio_cyc1: mode=%0d fault=%b, want mode=1 fault=0", mode, fault);
    end
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1 || fault_code !== 2'd1) begin
      errors++;
      $display("FAIL prio_code: mode=%0d fault=%b code=%0d, want mode=2 fault=1 code=1",
               mode, fault, fault_code);
    end
    set_lights(3'b100, 3'b001, 3'b111, 3'b100);
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1 || fault_code !== 2'd1) begin
      errors++;
      $display("FAIL first_fault_latch: mode=%0d fault=%b code=%0d, want mode=2 fault=1 code=1",
               mode, fault, fault_code);
    end
    clr_fault = 1'b1;
    tick();
    checks++;
    if (mode !== 2'd2 || fault !== 1'b1) begin
      errors++;
      $display("FAIL clear_blocked_illegal: mode=%0d fault=%b, want mode=2 fault=1", mode, fault);
    end
    set_lights(3'b100, 3'b001, 3'b100, 3'b100);
    tick();
    clr_fault = 1'b0;
    checks++;
    if (mode !== 2'd3 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL prio_clear: mode=%0d fault=%b code=%0d, want mode=3 fault=0 code=0",
               mode, fault, fault_code);
    end
  endtask

  task automatic test_reset_flash();
    for (int i = 0; i < 20 && mode !== 2'd1; i++) tick();
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL wait_run_timeout: mode=%0d, want mode=1", mode);
    end
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    tick();
    set_lights(3'b001, 3'b001, 3'b100, 3'b010);
    tick();
    tick();
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL rf_enter_flash: mode=%0d, want mode=2", mode);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (lamps !== ALL_OFF) begin
      errors++;
      $display("FAIL rf_off_phase: lamps=%h, want lamps=%h", lamps, ALL_OFF);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (lamps !== ALL_OFF || mode !== 2'd2 || fault !== 1'b1) begin
      errors++;
      $display("FAIL rst_not_async: lamps=%h mode=%0d fault=%b, want lamps=%h mode=2 fault=1",
               lamps, mode, fault, ALL_OFF);
    end
    tick();
    rst = 1'b0;
    set_lights(3'b001, 3'b001, 3'b100, 3'b100);
    checks++;
    if (lamps !== ALL_RED || mode !== 2'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_flash: lamps=%h mode=%0d fault=%b code=%0d, want lamps=%h mode=0 fault=0 code=0",
               lamps, mode, fault, fault_code, ALL_RED);
    end
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mode !== 2'd0 || lamps !== ALL_RED) begin
        errors++;
        $display("FAIL reinit_cycle%0d: mode=%0d lamps=%h, want mode=0 lamps=%h", i, mode, lamps, ALL_RED);
      end
      tick();
    end
    checks++;
    if (mode !== 2'd1 || lamps !== BASE) begin
      errors++;
      $display("FAIL reinit_to_run: mode=%0d lamps=%h, want mode=1 lamps=%h", mode, lamps, BASE);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_run_suppress();
    test_glitch();
    test_clear();
    test_skip_yellow();
    test_priority();
    test_reset_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter STARTUP_CYC, default 8: all-red cycles in INIT and RECOVER.
REQ-002 Parameter BLINK_HALF, default 4: cycles per on-phase and per off-phase of the fault flash.
REQ-003 Parameter FILTER, default 2: consecutive cycles a level fault must persist before confirmation; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 light_M1, light_M2, light_MT, light_S  input  3 each  controller lamp codes: 100 red, 010 yellow, 001 green.
REQ-007 clr_fault  input  1  operator fault clear, level-sampled.
REQ-008 lamp_M1, lamp_M2, lamp_MT, lamp_S  output  3 each  registered lamp drive, same encoding as the inputs.
REQ-009 fault  output  1  latched fault indicator.
REQ-010 fault_code  output  2  first confirmed fault: 0 none, 1 illegal code, 2 conflict, 3 skipped yellow.
REQ-011 mode  output  2  0 INIT, 1 RUN, 2 FLASH, 3 RECOVER.

Function
REQ-012 The FSM SHALL have states INIT, RUN, FLASH and RECOVER, with mode equal to the current state's encoding.
REQ-013 INIT SHALL drive all lamps to 100 for exactly STARTUP_CYC cycles, then enter RUN.
REQ-014 In RUN, each lamp_X SHALL equal light_X sampled at the previous edge (1-cycle latency).
REQ-015 An illegal-code condition SHALL be any input in {000,011,101,110,111}.
REQ-016 A conflict condition SHALL be any of: light_S non-red together with any of M1, M2 or MT non-red; light_MT non-red together with light_M2 non-red. M1 with M2, and M1 with MT, are permitted.
REQ-017 A skipped-yellow event SHALL be any input whose value at the previous edge was 001 and whose current value is 100; a per-input previous-value register SHALL be updated every cycle in every state.
REQ-018 Illegal-code and conflict conditions SHALL each have a saturating persistence counter, active only in RUN and cleared whenever its condition is false.
REQ-019 A level fault SHALL be confirmed at the edge that samples its FILTER-th consecutive true cycle; a skipped-yellow event SHALL be confirmed at the edge that samples it.
REQ-020 On confirmation, the block SHALL enter FLASH, set fault=1 and load fault_code; if faults are confirmed simultaneously, the priority SHALL be 1 > 2 > 3.
REQ-021 In FLASH, all four lamps SHALL drive 100 for BLINK_HALF cycles, then 000 for BLINK_HALF cycles, repeating; the first flash cycle SHALL be an on-cycle.
REQ-022 In FLASH, fault and fault_code SHALL hold, and no new fault SHALL be evaluated.
REQ-023 If clr_fault=1 in FLASH and the current inputs have neither an illegal-code nor a conflict condition, the block SHALL enter RECOVER at that edge; otherwise clr_fault SHALL be ignored.
REQ-024 On RECOVER entry, fault and fault_code SHALL clear to 0; RECOVER SHALL drive all lamps to 100 for STARTUP_CYC cycles, then enter RUN with cleared persistence counters.
REQ-025 clr_fault SHALL be ignored in INIT, RUN and RECOVER.
REQ-026 Skipped-yellow detection SHALL be suppressed on the first RUN cycle after INIT or RECOVER.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set state INIT, all counters 0, all lamps 100, fault 0, fault_code 0, mode 0, and all previous-value registers 100.
REQ-028 Reset SHALL take effect from any state, including mid-FLASH and mid-INIT, and SHALL restart the full STARTUP_CYC all-red period.
REQ-029 Reset SHALL have no asynchronous effect: asserting rst between edges SHALL not change any output.

Verification
REQ-030 Power-up: rst for 2 cycles, then legal inputs M1=001, M2=001, MT=100, S=100 -> lamps 100 and mode 0 for 8 cycles; mode 1 on the next cycle; lamps track inputs one cycle later.
REQ-031 Glitch filter: in RUN, S=001 with M1=001 for 1 cycle, then legal -> no fault; the same condition held for 2 cycles -> fault=1, fault_code=2, mode 2.
REQ-032 Skipped yellow: in RUN, M2 changes 001 to 100 directly -> FLASH at the sampling edge, fault_code=3, lamps 100 x4 then 000 x4, repeating.
REQ-033 Priority and first-fault latch: illegal code 111 on MT together with a conflict for 2 cycles -> fault_code=1; a later skipped yellow during FLASH -> fault_code stays 1.
REQ-034 Clear handling: clr_fault while inputs still conflict -> remains FLASH; clr_fault with legal inputs -> mode 3, fault=0, 8 red cycles, then RUN.
REQ-035 Reset mid-FLASH during an off-phase -> next edge lamps 100, mode 0, fault 0; 8-cycle INIT restarts.
